// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  regfile_pkg
//  Shared FSM state encoding and requester count for regfile_arbiter.
//  Revision: 1.0
// ============================================================================
package regfile_pkg;

  // Number of requesters sharing the register file
  localparam int NUM_REQ = 2;

  // Controller states
  localparam logic [0:0] ST_INIT = 1'b0;  // sweeping zeros into every register
  localparam logic [0:0] ST_RUN  = 1'b1;  // arbitrating requester accesses

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  rr_arb2
//  Two-way round-robin selector. A lone request wins outright; on a tie the
//  requester that was not granted most recently wins.
//  Revision: 1.0
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Pick at most one requester from this cycle's requests
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  regfile_arbiter
//  Clears an external register file after reset, then shares its single
//  write port / registered read port between two requesters using
//  round-robin arbitration. Reads return one cycle after the grant.
//  Revision: 1.0
// ============================================================================
module regfile_arbiter #(
  parameter int N  = 8,
  parameter int R  = 32,
  parameter int RR = $clog2(R)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [RR-1:0] id0,
  input  logic [RR-1:0] id1,
  input  logic [N-1:0]  wdata0,
  input  logic [N-1:0]  wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [N-1:0]  rdata,
  output logic          ready,
  output logic          rf_wr,
  output logic [RR-1:0] rf_id_w,
  output logic [RR-1:0] rf_id_r,
  output logic [N-1:0]  rf_data_in,
  input  logic [N-1:0]  rf_data_out
);

  import regfile_pkg::*;

  // Index + 1 modulo R; keeps the read index off the write index
  function automatic logic [RR-1:0] wrap_inc(input logic [RR-1:0] v);
    if (v == RR'(R - 1)) return '0;
    else                 return v + RR'(1);
  endfunction

  logic [0:0]         state;
  logic [RR-1:0]      cnt;
  logic               last;
  logic               rv0;
  logic               rv1;
  logic               run;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic               sel_we;
  logic [RR-1:0]      sel_id;
  logic [N-1:0]       sel_wdata;

  // A reset in progress suppresses every grant and pending read result
  assign run     = (state == ST_RUN) && !rst;
  assign arb_req = run ? {req1, req0} : '0;

  rr_arb2 u_arb (
    .req  (arb_req),
    .last (last),
    .gnt  (arb_gnt)
  );

  assign gnt0      = arb_gnt[0];
  assign gnt1      = arb_gnt[1];
  assign sel_we    = arb_gnt[1] ? we1    : we0;
  assign sel_id    = arb_gnt[1] ? id1    : id0;
  assign sel_wdata = arb_gnt[1] ? wdata1 : wdata0;

  assign ready   = run;
  assign rvalid0 = rv0 && !rst;
  assign rvalid1 = rv1 && !rst;
  assign rdata   = rf_data_out;

  // Register-file port drive: clear sweep in INIT, granted access in RUN
  always_comb begin
    rf_wr      = 1'b0;
    rf_id_w    = '0;
    rf_id_r    = '0;
    rf_data_in = '0;
    if (!rst) begin
      if (state == ST_INIT) begin
        rf_wr   = 1'b1;
        rf_id_w = cnt;
        rf_id_r = wrap_inc(cnt);
      end else if (|arb_gnt) begin
        if (sel_we) begin
          rf_wr      = 1'b1;
          rf_id_w    = sel_id;
          rf_id_r    = wrap_inc(sel_id);
          rf_data_in = sel_wdata;
        end else begin
          rf_id_r = sel_id;
          rf_id_w = sel_id;
        end
      end
    end
  end

  // FSM, sweep counter, last-grant pointer and one-deep read-valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
      last  <= 1'b1;
      rv0   <= 1'b0;
      rv1   <= 1'b0;
    end else begin
      rv0 <= arb_gnt[0] && !we0;
      rv1 <= arb_gnt[1] && !we1;
      if (state == ST_INIT) begin
        if (cnt == RR'(R - 1)) begin
          state <= ST_RUN;
          cnt   <= '0;
        end else begin
          cnt <= cnt + RR'(1);
        end
      end else if (|arb_gnt) begin
        last <= arb_gnt[1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// ============================================================================
//  tb_regfile_arbiter
//  Directed self-checking bench for regfile_arbiter with a behavioural
//  register file (registered read, synchronous write) attached.
//  Revision: 1.0
// ============================================================================
module tb_regfile_arbiter;

  localparam int N  = 8;
  localparam int R  = 32;
  localparam int RR = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [RR-1:0] id0, id1;
  logic [N-1:0]  wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, ready;
  logic [N-1:0]  rdata;
  logic          rf_wr;
  logic [RR-1:0] rf_id_w, rf_id_r;
  logic [N-1:0]  rf_data_in;
  logic [N-1:0]  rf_data_out;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] mem [R];

  regfile_arbiter #(.N(N), .R(R), .RR(RR)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .id0         (id0),
    .id1         (id1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .rvalid0     (rvalid0),
    .rvalid1     (rvalid1),
    .rdata       (rdata),
    .ready       (ready),
    .rf_wr       (rf_wr),
    .rf_id_w     (rf_id_w),
    .rf_id_r     (rf_id_r),
    .rf_data_in  (rf_data_in),
    .rf_data_out (rf_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural register file: synchronous write, registered read
  always @(posedge clk) begin
    if (rf_wr) mem[rf_id_w] <= rf_data_in;
    rf_data_out <= mem[rf_id_r];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input int i0, input int d0,
                       input logic r1, input logic w1, input int i1, input int d1);
    req0 = r0; we0 = w0; id0 = RR'(i0); wdata0 = N'(d0);
    req1 = r1; we1 = w1; id1 = RR'(i1); wdata1 = N'(d1);
  endtask

  // From a negedge: advance one cycle and settle after the next negedge
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Counts INIT cycles after reset release; every one must show no grant
  task automatic run_init(input string tag);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      check({tag, "_gnt0"}, gnt0, 0);
      check({tag, "_gnt1"}, gnt1, 0);
      if (n == 0 || n == R - 1) begin
        check({tag, "_wr"},  rf_wr, 1);
        check({tag, "_idw"}, rf_id_w, n);
        check({tag, "_idr"}, rf_id_r, (n + 1) % R);
        check({tag, "_din"}, rf_data_in, 0);
      end
      n++;
      next_cycle();
    end
    check({tag, "_len"}, n, R);
  endtask

  initial begin
    for (int i = 0; i < R; i++) mem[i] = 8'hFF;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);

    // Reset with a request pending: nothing granted, no write strobe
    @(negedge clk);
    drive(1, 1, 3, 8'h11, 0, 0, 0, 0);
    #1;
    check("rst_wr",    rf_wr, 0);
    check("rst_gnt0",  gnt0, 0);
    check("rst_ready", ready, 0);
    check("rst_rv",    {rvalid1, rvalid0}, 0);

    // Release with both requesters holding reads of ids 1 and 2
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 1, 0, 1, 0, 2, 0);
    #1;
    run_init("init");
    check("ready_up", ready, 1);

    // Continuous tie: grants alternate starting with requester 0
    for (int i = 0; i < 6; i++) begin
      check("alt_gnt0", gnt0, (i % 2) == 0);
      check("alt_gnt1", gnt1, (i % 2) == 1);
      check("alt_idr",  rf_id_r, (i % 2) == 0 ? 1 : 2);
      check("alt_wr",   rf_wr, 0);
      if (i > 0) begin
        check("alt_rv", {rvalid1, rvalid0}, (i % 2) == 1 ? 2'b01 : 2'b10);
        check("alt_rd", rdata, 0);
      end
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("alt_rv_last", {rvalid1, rvalid0}, 2'b10);
    check("idle_wr", rf_wr, 0);
    next_cycle();
    check("idle_rv", {rvalid1, rvalid0}, 0);

    // Every register reads back zero after the clear sweep
    for (int k = 0; k <= R; k++) begin
      if (k < R) drive(1, 0, k, 0, 0, 0, 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      if (k > 0) begin
        check("clr_rv", rvalid0, 1);
        check("clr_rd", rdata, 0);
      end
      next_cycle();
    end

    // Write by requester 0, then read of the same index by requester 1
    drive(1, 1, 5, 8'hA5, 0, 0, 0, 0);
    #1;
    check("wr5_gnt",  {gnt1, gnt0}, 2'b01);
    check("wr5_wr",   rf_wr, 1);
    check("wr5_idw",  rf_id_w, 5);
    check("wr5_idr",  rf_id_r, 6);
    check("wr5_din",  rf_data_in, 8'hA5);
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 5, 0);
    #1;
    check("rd5_gnt",  {gnt1, gnt0}, 2'b10);
    check("rd5_wr",   rf_wr, 0);
    check("rd5_idr",  rf_id_r, 5);
    check("rd5_idw",  rf_id_w, 5);
    check("wr5_norv", {rvalid1, rvalid0}, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rd5_rv",   {rvalid1, rvalid0}, 2'b10);
    check("rd5_data", rdata, 8'hA5);
    next_cycle();

    // Top index write wraps the read index to 0
    drive(0, 0, 0, 0, 1, 1, 31, 8'h3C);
    #1;
    check("wr31_gnt", {gnt1, gnt0}, 2'b10);
    check("wr31_idw", rf_id_w, 31);
    check("wr31_idr", rf_id_r, 0);
    next_cycle();
    drive(1, 0, 31, 0, 0, 0, 0, 0);
    #1;
    check("rd31_gnt", gnt0, 1);
    next_cycle();
    drive(1, 1, 7, 8'h77, 0, 0, 0, 0);
    #1;
    check("rd31_rv",   rvalid0, 1);
    check("rd31_data", rdata, 8'h3C);
    next_cycle();

    // Reset while a read is outstanding
    drive(1, 0, 7, 0, 0, 0, 0, 0);
    #1;
    check("pre_rst_gnt", gnt0, 1);
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("mid_rst_rv",    {rvalid1, rvalid0}, 0);
    check("mid_rst_ready", ready, 0);
    check("mid_rst_wr",    rf_wr, 0);
    next_cycle();
    check("post_rst_rv",    {rvalid1, rvalid0}, 0);
    check("post_rst_ready", ready, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 0, 7, 0);
    #1;
    run_init("reinit");

    // Register 7 was cleared again; requester 1 alone is granted
    check("re_rd7_gnt", {gnt1, gnt0}, 2'b10);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("re_rd7_rv",   rvalid1, 1);
    check("re_rd7_data", rdata, 0);
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence stalls
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
